// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and default thresholds for the sync_fifo_flags FIFO family.
package sync_fifo_pkg;

    localparam int AE_THRESH_DEF = 2;
    localparam int AF_MARGIN_DEF = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Handshake, data and status bundle between a FIFO user (master) and sync_fifo_flags (slave).
interface sync_fifo_flags_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) ();

    logic                      wr_en;
    logic [WIDTH-1:0]          wr_data;
    logic                      rd_en;
    logic [WIDTH-1:0]          rd_data;
    logic                      rd_valid;
    logic                      err_clr;
    logic [cnt_w(DEPTH)-1:0]   count;
    logic                      empty;
    logic                      full;
    logic                      almost_empty;
    logic                      almost_full;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read port by default,
// asynchronous read port when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic                    rst,
    input  logic                    re,
`endif
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem_q[raddr];
`else
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Output register holds its word between pops; only this register is reset, never the array.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - AF_MARGIN_DEF,
    parameter int AE_THRESH = AE_THRESH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_flags_if.slave bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

    if (WIDTH < 1) begin : g_chk_width
        $error("sync_fifo_flags: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("sync_fifo_flags: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("sync_fifo_flags: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
        $error("sync_fifo_flags: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          empty, full;
    logic          wr_acc, rd_acc;

    // Status flags decode only registered state, so they never glitch on input changes.
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    always_comb begin
        wr_acc   = bus.wr_en && !full;
        rd_acc   = bus.rd_en && !empty;
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new rejection outranks a same-cycle clear so that no error event is lost.
        overflow_d  = (bus.wr_en && full)  || (overflow_q  && !bus.err_clr);
        underflow_d = (bus.rd_en && empty) || (underflow_q && !bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.rd_valid = !empty;
`else
    logic rd_valid_q, rd_valid_d;

    assign rd_valid_d = rd_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
`endif

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst   (rst),
        .re    (rd_acc),
`endif
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (bus.rd_data)
    );

    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_flags #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the FIFO contents as a queue plus the observable registers.
    logic [7:0] q[$];
    bit         m_ovf, m_unf, m_rv;
    logic [7:0] m_rd;

    typedef struct {
        bit         wr;
        bit         rd;
        bit         clr;
        logic [7:0] d;
        int         cnt;
        bit         full;
        bit         af;
        bit         ae;
        bit         ovf;
        bit         unf;
        bit         rv;
        logic [7:0] rdata;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("count", 32'(bus.count), 32'(sz));
        chk("empty", 32'(bus.empty), 32'(sz == 0));
        chk("full", 32'(bus.full), 32'(sz == DEPTH));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
        chk("almost_full", 32'(bus.almost_full), 32'(sz >= AF));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rd_valid", 32'(bus.rd_valid), 32'(sz != 0));
        if (sz != 0) chk("rd_data", 32'(bus.rd_data), 32'(q[0]));
`else
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
`endif
    endtask

    task automatic cycle(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit was_full, was_empty;
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_en   = rd;
        bus.err_clr = clr;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk);
        m_ovf = (wr && was_full) || (m_ovf && !clr);
        m_unf = (rd && was_empty) || (m_unf && !clr);
        m_rv  = rd && !was_empty;
        if (rd && !was_empty) m_rd = q.pop_front();
        if (wr && !was_full) q.push_back(d);
        #1;
        check_model();
    endtask

    // Requests stay asserted during reset: reset must win over them.
    task automatic do_reset();
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = 8'hEE;
        bus.err_clr = 1'b0;
        @(posedge clk);
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = 8'h00;
        #1;
        check_model();
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   pw;
        int   pr;

        // Directed table: fill past full, drain past empty, then clear errors.
        for (int i = 0; i <= DEPTH; i++) begin
            v = '{wr: 1'b1, rd: 1'b0, clr: 1'b0, d: 8'(i + 1),
                  cnt: (i < DEPTH) ? i + 1 : DEPTH,
                  full: (i + 1 >= DEPTH), af: (i + 1 >= AF), ae: (i + 1 <= AE),
                  ovf: (i == DEPTH), unf: 1'b0, rv: 1'b0, rdata: 8'h00};
            tab.push_back(v);
        end
        for (int j = 0; j < DEPTH; j++) begin
            v = '{wr: 1'b0, rd: 1'b1, clr: 1'b0, d: 8'h00,
                  cnt: DEPTH - 1 - j, full: 1'b0,
                  af: (DEPTH - 1 - j >= AF), ae: (DEPTH - 1 - j <= AE),
                  ovf: 1'b1, unf: 1'b0, rv: 1'b1, rdata: 8'(j + 1)};
            tab.push_back(v);
        end
        tab.push_back('{wr: 1'b0, rd: 1'b1, clr: 1'b0, d: 8'h00, cnt: 0, full: 1'b0,
                        af: 1'b0, ae: 1'b1, ovf: 1'b1, unf: 1'b1, rv: 1'b0, rdata: 8'h10});
        tab.push_back('{wr: 1'b0, rd: 1'b0, clr: 1'b1, d: 8'h00, cnt: 0, full: 1'b0,
                        af: 1'b0, ae: 1'b1, ovf: 1'b0, unf: 1'b0, rv: 1'b0, rdata: 8'h10});

        do_reset();
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_almost_empty", 32'(bus.almost_empty), 32'd1);

        foreach (tab[k]) begin
            cycle(tab[k].wr, tab[k].d, tab[k].rd, tab[k].clr);
            chk("tab_count", 32'(bus.count), 32'(tab[k].cnt));
            chk("tab_full", 32'(bus.full), 32'(tab[k].full));
            chk("tab_almost_full", 32'(bus.almost_full), 32'(tab[k].af));
            chk("tab_almost_empty", 32'(bus.almost_empty), 32'(tab[k].ae));
            chk("tab_overflow", 32'(bus.overflow), 32'(tab[k].ovf));
            chk("tab_underflow", 32'(bus.underflow), 32'(tab[k].unf));
`ifndef SYNC_FIFO_FWFT_EN
            chk("tab_rd_valid", 32'(bus.rd_valid), 32'(tab[k].rv));
            chk("tab_rd_data", 32'(bus.rd_data), 32'(tab[k].rdata));
`endif
        end

        // Steady state at half full with simultaneous traffic across pointer wrap.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        chk("steady_count", 32'(bus.count), 32'd8);
        chk("steady_overflow", 32'(bus.overflow), 32'd0);

        // Full with write and read together: read wins, write rejected.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        chk("fullrw_count", 32'(bus.count), 32'(DEPTH - 1));
        chk("fullrw_overflow", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("fullrw_clr", 32'(bus.overflow), 32'd0);

        // Empty with write and read together: write wins, read rejected.
        do_reset();
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("emptyrw_count", 32'(bus.count), 32'd1);
        chk("emptyrw_underflow", 32'(bus.underflow), 32'd1);

        // Reset in the middle of operation with a pending error flag.
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_reset();
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_empty", 32'(bus.empty), 32'd1);
        chk("midrst_underflow", 32'(bus.underflow), 32'd0);
        chk("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
        do_reset();
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_empty", 32'(bus.empty), 32'd0);
        chk("fwft_rd_data", 32'(bus.rd_data), 32'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_pop_empty", 32'(bus.empty), 32'd1);
`endif

        // Randomized traffic in phases biased toward filling, draining and balance.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ((i / 300) % 3)
                0:       begin pw = 75; pr = 30; end
                1:       begin pw = 30; pr = 75; end
                default: begin pw = 55; pr = 55; end
            endcase
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < pw, 8'($urandom_range(0, 255)),
                      $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
